// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues in-order fetches to instruction memory, tracks
// outstanding PCs, queues responses for decode, drops stale responses after a
// flush. Optional same-cycle bypass of responses when FETCH_UNIT_BYPASS_EN is defined.
module fetch_unit #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PC_WIDTH-1:0]    current_pc,
  output logic                   pc_en,
  input  logic                   flush,
  output logic                   imem_req_valid,
  output logic [PC_WIDTH-1:0]    imem_req_addr,
  input  logic                   imem_req_ready,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
  input  logic                   instr_ready
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  logic [PC_WIDTH-1:0]    pcq_mem_r [QUEUE_DEPTH];
  logic [PTR_W-1:0]       pcq_wr_r;
  logic [PTR_W-1:0]       pcq_rd_r;
  logic [INSTR_WIDTH-1:0] iq_instr_r [QUEUE_DEPTH];
  logic [PC_WIDTH-1:0]    iq_pc_r [QUEUE_DEPTH];
  logic [PTR_W-1:0]       iq_wr_r;
  logic [PTR_W-1:0]       iq_rd_r;
  logic [CNT_W-1:0]       outstanding_r;
  logic [CNT_W-1:0]       drop_cnt_r;
  logic [CNT_W-1:0]       queued_r;

  logic [CNT_W+1:0]       in_flight_s;
  logic [CNT_W:0]         owed_s;
  logic [CNT_W:0]         drop_load_s;
  logic                   req_fire_s;
  logic                   rsp_live_s;
  logic                   rsp_drop_s;
  logic                   head_valid_s;
  logic                   bypass_s;
  logic                   push_s;
  logic                   pop_s;

  // Dropped responses still occupy memory slots, so they count against the issue limit.
  assign in_flight_s    = {2'b00, outstanding_r} + {2'b00, drop_cnt_r} + {2'b00, queued_r};
  assign imem_req_valid = !rst && !flush && (in_flight_s < (CNT_W + 2)'(QUEUE_DEPTH));
  assign imem_req_addr  = current_pc;
  assign req_fire_s     = imem_req_valid && imem_req_ready;
  assign pc_en          = req_fire_s;

  assign rsp_live_s   = !rst && !flush && imem_rsp_valid && (drop_cnt_r == {CNT_W{1'b0}});
  assign rsp_drop_s   = imem_rsp_valid && (drop_cnt_r != {CNT_W{1'b0}});
  assign head_valid_s = (queued_r != {CNT_W{1'b0}});

`ifdef FETCH_UNIT_BYPASS_EN
  assign bypass_s = rsp_live_s && !head_valid_s && instr_ready;
`else
  assign bypass_s = 1'b0;
`endif

  assign push_s = rsp_live_s && !bypass_s;
  assign pop_s  = !rst && head_valid_s && instr_ready;

  assign instr_valid = !rst && (head_valid_s || bypass_s);
  assign instr       = bypass_s ? imem_rsp_data : iq_instr_r[iq_rd_r];
  assign instr_pc    = bypass_s ? pcq_mem_r[pcq_rd_r] : iq_pc_r[iq_rd_r];

  // A response landing in the flush cycle is consumed, so it is not owed any more.
  assign owed_s      = {1'b0, outstanding_r} + {1'b0, drop_cnt_r};
  assign drop_load_s = (imem_rsp_valid && (owed_s != {(CNT_W + 1){1'b0}})) ?
                       (owed_s - (CNT_W + 1)'(1)) : owed_s;

  // Outstanding-PC FIFO: written on request handshake, read on each accepted response.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcq_wr_r <= {PTR_W{1'b0}};
      pcq_rd_r <= {PTR_W{1'b0}};
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        pcq_mem_r[i] <= {PC_WIDTH{1'b0}};
      end
    end else if (flush) begin
      pcq_wr_r <= {PTR_W{1'b0}};
      pcq_rd_r <= {PTR_W{1'b0}};
    end else begin
      if (req_fire_s) begin
        pcq_mem_r[pcq_wr_r] <= current_pc;
        pcq_wr_r            <= pcq_wr_r + PTR_W'(1);
      end
      if (rsp_live_s) begin
        pcq_rd_r <= pcq_rd_r + PTR_W'(1);
      end
    end
  end

  // Instruction queue storage and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      iq_wr_r <= {PTR_W{1'b0}};
      iq_rd_r <= {PTR_W{1'b0}};
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        iq_instr_r[i] <= {INSTR_WIDTH{1'b0}};
        iq_pc_r[i]    <= {PC_WIDTH{1'b0}};
      end
    end else if (flush) begin
      iq_wr_r <= {PTR_W{1'b0}};
      iq_rd_r <= {PTR_W{1'b0}};
    end else begin
      if (push_s) begin
        iq_instr_r[iq_wr_r] <= imem_rsp_data;
        iq_pc_r[iq_wr_r]    <= pcq_mem_r[pcq_rd_r];
        iq_wr_r             <= iq_wr_r + PTR_W'(1);
      end
      if (pop_s) begin
        iq_rd_r <= iq_rd_r + PTR_W'(1);
      end
    end
  end

  // Occupancy counters: outstanding requests, responses to drop, queued entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_r <= {CNT_W{1'b0}};
      drop_cnt_r    <= {CNT_W{1'b0}};
      queued_r      <= {CNT_W{1'b0}};
    end else if (flush) begin
      outstanding_r <= {CNT_W{1'b0}};
      drop_cnt_r    <= drop_load_s[CNT_W-1:0];
      queued_r      <= {CNT_W{1'b0}};
    end else begin
      case ({req_fire_s, rsp_live_s})
        2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
        2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
        default: outstanding_r <= outstanding_r;
      endcase
      if (rsp_drop_s) begin
        drop_cnt_r <= drop_cnt_r - CNT_W'(1);
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
      case ({push_s, pop_s})
        2'b10:   queued_r <= queued_r + CNT_W'(1);
        2'b01:   queued_r <= queued_r - CNT_W'(1);
        default: queued_r <= queued_r;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run,
// all checked against an epoch-based reference model of fetch order.
module tb_fetch_unit;

  localparam int DEPTH = 4;
`ifdef FETCH_UNIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] current_pc = 32'd0;
  logic        pc_en;
  logic        flush = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .current_pc(current_pc), .pc_en(pc_en), .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Memory: in-order responder with configurable latency and hold.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mem_ent_t;

  mem_ent_t    mem_q[$];
  logic [31:0] exp_q[$];
  int          ans = 0;
  int          epoch = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  bit          mem_hold = 1'b0;
  logic [31:0] flush_pc = 32'd0;
  logic [31:0] pc_next = 32'd0;

  always @(posedge clk) begin
    current_pc <= pc_next;
  end

  always @(posedge clk) begin
    cyc++;
    #2;
    if (mem_q.size() > 0 && !mem_hold && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'd0;
    end
  end

  // Reference model: every fetch since the last flush must reach decode in order.
  always @(negedge clk) begin
    bit live;
    bit exp_rv;
    bit exp_iv;
    if (rst) begin
      mem_q.delete();
      exp_q.delete();
      ans = 0;
      epoch++;
      pc_next = 32'd0;
    end else begin
      live   = imem_rsp_valid && mem_q.size() > 0 && mem_q[0].epoch == epoch && !flush;
      exp_rv = !flush && ((mem_q.size() + ans) < DEPTH);
      exp_iv = (ans > 0) || (BYP && live && instr_ready);

      total++;
      if (imem_req_addr !== current_pc) begin
        bad++; $display("FAIL req_addr: got %0h want %0h", imem_req_addr, current_pc);
      end
      total++;
      if (imem_req_valid !== exp_rv) begin
        bad++; $display("FAIL req_valid: got %b want %b at cyc %0d", imem_req_valid, exp_rv, cyc);
      end
      total++;
      if (pc_en !== (exp_rv && imem_req_ready)) begin
        bad++; $display("FAIL pc_en: got %b want %b at cyc %0d", pc_en, exp_rv && imem_req_ready, cyc);
      end
      total++;
      if (instr_valid !== exp_iv) begin
        bad++; $display("FAIL instr_valid: got %b want %b at cyc %0d", instr_valid, exp_iv, cyc);
      end
      if (exp_iv && instr_valid === 1'b1 && exp_q.size() > 0) begin
        total++;
        if (instr_pc !== exp_q[0]) begin
          bad++; $display("FAIL instr_pc: got %0h want %0h at cyc %0d", instr_pc, exp_q[0], cyc);
        end
        total++;
        if (instr !== mem_word(exp_q[0])) begin
          bad++; $display("FAIL instr: got %0h want %0h at cyc %0d", instr, mem_word(exp_q[0]), cyc);
        end
      end

      if (imem_rsp_valid && mem_q.size() > 0) mem_q.pop_front();
      if (live) ans++;
      if (exp_iv && instr_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        ans--;
      end
      if (flush) begin
        exp_q.delete();
        ans = 0;
        epoch++;
      end
      if (exp_rv && imem_req_ready) begin
        exp_q.push_back(current_pc);
        mem_q.push_back('{addr: current_pc, epoch: epoch, due: cyc + mem_lat});
      end
      pc_next = flush ? flush_pc : (pc_en ? current_pc + 32'd1 : current_pc);
    end
  end

  task automatic apply_reset();
    rst = 1'b1; flush = 1'b0; mem_hold = 1'b0; imem_req_ready = 1'b0;
    instr_ready = 1'b0; flush_pc = 32'd0; mem_lat = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
      total++;
      if (pc_en !== 1'b0) begin bad++; $display("FAIL rst_pc_en: got %b want 0", pc_en); end
      total++;
      if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
    end
    total++;
    if (instr !== 32'd0) begin bad++; $display("FAIL rst_instr: got %0h want 0", instr); end
    total++;
    if (instr_pc !== 32'd0) begin bad++; $display("FAIL rst_instr_pc: got %0h want 0", instr_pc); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL first_req_valid: got %b want 1", imem_req_valid); end
    total++;
    if (imem_req_addr !== 32'd0) begin bad++; $display("FAIL first_req_addr: got %0h want 0", imem_req_addr); end
    @(posedge clk); #1;
  endtask

  task automatic test_streaming();
    int first;
    first = BYP ? 1 : 2;
    apply_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      total++;
      if (i < first) begin
        if (instr_valid !== 1'b0) begin bad++; $display("FAIL stream_lat: got valid %b want 0 at %0d", instr_valid, i); end
      end else if (instr_valid !== 1'b1 || instr_pc !== 32'(i - first)) begin
        bad++; $display("FAIL stream_pc: got v=%b pc=%0h want v=1 pc=%0h", instr_valid, instr_pc, i - first);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int n;
    int nxt;
    apply_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (pc_en === 1'b1) n++;
      if (i == 11) begin
        total++;
        if (pc_en !== 1'b0) begin bad++; $display("FAIL bp_stall: got pc_en %b want 0", pc_en); end
      end
      @(posedge clk); #1;
    end
    total++;
    if (n != DEPTH) begin bad++; $display("FAIL bp_count: got %0d want %0d", n, DEPTH); end
    instr_ready = 1'b1;
    nxt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid === 1'b1) begin
        total++;
        if (instr_pc !== 32'(nxt)) begin bad++; $display("FAIL bp_order: got %0h want %0h", instr_pc, nxt); end
        nxt++;
      end
      @(posedge clk); #1;
    end
    total++;
    if (nxt < 12) begin bad++; $display("FAIL bp_resume: got %0d deliveries want >=12", nxt); end
  endtask

  task automatic test_flush();
    int seen;
    apply_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_hold = 1'b1;
    @(posedge clk); #1;
    flush = 1'b1; flush_pc = 32'd15;
    @(negedge clk);
    total++;
    if (imem_req_valid !== 1'b0 || pc_en !== 1'b0) begin
      bad++; $display("FAIL flush_req: got req_valid %b pc_en %b want 0 0", imem_req_valid, pc_en);
    end
    total++;
    if (instr_valid !== 1'b1) begin bad++; $display("FAIL flush_queued: got %b want 1", instr_valid); end
    @(posedge clk); #1;
    flush = 1'b0; mem_hold = 1'b0; instr_ready = 1'b1;
    seen = -1;
    for (int c = 4; c < 14; c++) begin
      @(negedge clk);
      if (instr_valid === 1'b1 && seen < 0) begin
        seen = c;
        total++;
        if (instr_pc !== 32'd15) begin bad++; $display("FAIL flush_pc: got %0h want f", instr_pc); end
      end
      @(posedge clk); #1;
    end
    total++;
    if (seen != (BYP ? 6 : 7)) begin bad++; $display("FAIL flush_resume: got cycle %0d want %0d", seen, BYP ? 6 : 7); end
  endtask

  task automatic test_simultaneous();
    int nxt;
    apply_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    @(posedge clk); #1;
    imem_req_ready = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b1;
    @(negedge clk);
    total++;
    if (pc_en !== 1'b1 || imem_rsp_valid !== 1'b1 || instr_pc !== 32'd0) begin
      bad++; $display("FAIL simul_events: got pc_en %b rsp %b pc %0h want 1 1 0", pc_en, imem_rsp_valid, instr_pc);
    end
    @(posedge clk); #1;
    imem_req_ready = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    total++;
    if (imem_req_valid !== 1'b1 || instr_pc !== 32'd1) begin
      bad++; $display("FAIL simul_state: got req_valid %b pc %0h want 1 1", imem_req_valid, instr_pc);
    end
    @(posedge clk); #1;
    imem_req_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL simul_full: got %b want 0", imem_req_valid); end
    @(posedge clk); #1;
    imem_req_ready = 1'b0; instr_ready = 1'b1;
    nxt = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (instr_valid === 1'b1) begin
        total++;
        if (instr_pc !== 32'(nxt)) begin bad++; $display("FAIL simul_order: got %0h want %0h", instr_pc, nxt); end
        nxt++;
      end
      @(posedge clk); #1;
    end
    total++;
    if (nxt != 5) begin bad++; $display("FAIL simul_drain: got %0d want 5", nxt); end
  endtask

  task automatic test_bypass();
    apply_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    @(negedge clk);
    total++;
    if (instr_valid !== BYP) begin bad++; $display("FAIL byp_rsp_cycle: got %b want %b", instr_valid, BYP); end
    if (instr_valid === 1'b1) begin
      total++;
      if (instr_pc !== 32'd0) begin bad++; $display("FAIL byp_pc: got %0h want 0", instr_pc); end
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (instr_valid !== !BYP) begin bad++; $display("FAIL byp_next_cycle: got %b want %b", instr_valid, !BYP); end
    if (instr_valid === 1'b1) begin
      total++;
      if (instr_pc !== 32'd0) begin bad++; $display("FAIL byp_q_pc: got %0h want 0", instr_pc); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int delivered;
    apply_reset();
    mem_lat = int'($urandom_range(1, 3));
    delivered = 0;
    for (int i = 0; i < 600; i++) begin
      imem_req_ready = ($urandom % 4) != 0;
      instr_ready    = ($urandom % 3) != 0;
      mem_hold       = ($urandom % 5) == 0;
      flush          = ($urandom % 25) == 0;
      flush_pc       = $urandom;
      if (i % 150 == 0) mem_lat = int'($urandom_range(1, 3));
      @(negedge clk);
      if (instr_valid === 1'b1 && instr_ready) delivered++;
      @(posedge clk); #1;
    end
    flush = 1'b0; mem_hold = 1'b0;
    total++;
    if (delivered < 50) begin bad++; $display("FAIL rand_progress: got %0d deliveries want >=50", delivered); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_simultaneous();
    test_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_WIDTH, default 32: width of all PC and address signals.
REQ-002 Parameter INSTR_WIDTH, default 32: width of the instruction word.
REQ-003 Parameter QUEUE_DEPTH, default 4: the instruction queue and the outstanding-PC FIFO SHALL each hold QUEUE_DEPTH entries; the value SHALL be a power of two, at least 2.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 current_pc  in  PC_WIDTH  PC of the next instruction to fetch, driven by pc_ctr.
REQ-007 pc_en  out  1  advance enable to pc_ctr en; high SHALL mean current_pc is consumed this cycle.
REQ-008 flush  in  1  redirect; pc_ctr loads the new PC in the same cycle.
REQ-009 imem_req_valid  out  1  fetch request valid.
REQ-010 imem_req_addr  out  PC_WIDTH  fetch address; SHALL equal current_pc.
REQ-011 imem_req_ready  in  1  memory accepts the request.
REQ-012 imem_rsp_valid  in  1  response valid; responses return in request order, one per cycle maximum.
REQ-013 imem_rsp_data  in  INSTR_WIDTH  fetched instruction.
REQ-014 instr_valid  out  1  queue head valid to decode.
REQ-015 instr  out  INSTR_WIDTH  queue head instruction.
REQ-016 instr_pc  out  PC_WIDTH  PC of the queue head.
REQ-017 instr_ready  in  1  decode accepts the head.

Function
REQ-018 The unit SHALL assert imem_req_valid when flush is low and (outstanding + queued) < QUEUE_DEPTH.
- outstanding: requests issued and not yet answered.
- queued: entries held in the instruction queue.
REQ-019 The unit SHALL assert pc_en only in a cycle where imem_req_valid and imem_req_ready are both high (a request handshake).
REQ-020 On a request handshake, the unit SHALL push current_pc into the outstanding-PC FIFO and increment outstanding.
REQ-021 On imem_rsp_valid, the unit SHALL pop the outstanding-PC FIFO, decrement outstanding, and write {instr, PC} into the instruction queue.
- If a request handshake and a response occur in the same cycle, outstanding SHALL remain unchanged.
REQ-022 The output SHALL be in-order FIFO semantics.
- instr_valid is high whenever queued > 0.
- A pop occurs when instr_valid and instr_ready are both high.
- A push and a pop in the same cycle SHALL both take effect.
REQ-023 The queue SHALL never overflow, because of the issue limit in REQ-018; the responder is not back-pressured.
REQ-024 Minimum latency from request handshake to instr_valid SHALL be memory latency + 1 cycle (registered queue).
REQ-025 On flush, the unit SHALL do all of the following in that cycle:
- empty the instruction queue, so instr_valid is low next cycle;
- load drop_cnt with the number of responses still owed, counting a response arriving in the flush cycle as already consumed;
- clear the outstanding-PC FIFO;
- suppress any request in that cycle.
REQ-026 While drop_cnt > 0, each imem_rsp_valid SHALL be discarded and SHALL decrement drop_cnt.
- New requests may issue while responses are being dropped.
- The issue limit in REQ-018 SHALL count drop_cnt as outstanding.
REQ-027 All counters SHALL be sized to count 0..QUEUE_DEPTH inclusive; FIFO pointers SHALL wrap modulo QUEUE_DEPTH.

Reset
REQ-028 While rst is high, the next edge SHALL clear both FIFOs, outstanding and drop_cnt.
REQ-029 While rst is high, imem_req_valid, pc_en and instr_valid SHALL be 0.
REQ-030 instr and instr_pc SHALL reset to 0.
REQ-031 A reset mid-operation SHALL abandon in-flight responses with no drop tracking; the memory is reset together with this unit.

Configuration
REQ-032 With macro FETCH_UNIT_BYPASS_EN defined, a response that arrives while the queue is empty and instr_ready is high SHALL pass combinationally to instr, instr_pc and instr_valid in the same cycle and SHALL not be written into the queue.
REQ-033 Without FETCH_UNIT_BYPASS_EN, every response SHALL pass through the queue (latency per REQ-024).

Verification
REQ-034 Reset: rst high for 2 cycles -> imem_req_valid=0, pc_en=0, instr_valid=0; first request after release uses addr = current_pc (0).
REQ-035 Streaming: 1-cycle memory, ready always high -> PCs 0,1,2,3... appear on instr_pc in order, one per cycle after the initial latency.
REQ-036 Back-pressure: instr_ready=0 with depth 4 -> exactly 4 requests issue, then pc_en stays 0.
- After instr_ready=1, issue resumes with no loss or duplication.
REQ-037 Flush: flush with 2 requests outstanding and 1 entry queued; pc_ctr loads 15 -> the 2 stale responses are dropped, instr_valid stays 0 until the response for PC 15, and the next instr_pc is 15.
REQ-038 Simultaneous events: in one cycle, a response push, a decode pop and a request issue -> queued and outstanding unchanged, order preserved.
REQ-039 Macro: with FETCH_UNIT_BYPASS_EN, empty queue and instr_ready=1 -> instr_valid in the response cycle; without it -> instr_valid one cycle later.
